// File: rtl/led_mode_ctrl_if.sv
// rtl/led_mode_ctrl_if.sv - key, brightness and duty/status bundle of the LED mode controller
interface led_mode_ctrl_if;
    logic        key_mode;
    logic        key_pause;
    logic [7:0]  bright_level;
    logic [31:0] duty_bus;
    logic [1:0]  mode_out;
    logic        paused;
    logic        tick;

    modport master (
        output key_mode, key_pause, bright_level,
        input  duty_bus, mode_out, paused, tick
    );

    modport slave (
        input  key_mode, key_pause, bright_level,
        output duty_bus, mode_out, paused, tick
    );
endinterface

// File: rtl/led_mode_ctrl.sv
// rtl/led_mode_ctrl.sv - display mode FSM, step prescaler and per-channel duty generation for four PWM LEDs
module led_mode_ctrl #(
    parameter int STEP_N    = 187500,
    parameter int CHASE_DIV = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    led_mode_ctrl_if.slave  bus
);
    localparam int PW = $clog2(STEP_N);
    localparam int CW = (CHASE_DIV > 1) ? $clog2(CHASE_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(STEP_N - 1);
    localparam logic [CW-1:0] CHASE_LAST = CW'(CHASE_DIV - 1);

    typedef enum logic [1:0] {
        MODE_OFF    = 2'd0,
        MODE_STEADY = 2'd1,
        MODE_BREATH = 2'd2,
        MODE_CHASE  = 2'd3
    } mode_e;

    mode_e         mode_q, mode_d;
    logic          paused_q, paused_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [7:0]    level_q, level_d;
    logic          dir_down_q, dir_down_d;
    logic [1:0]    idx_q, idx_d;
    logic [CW-1:0] chase_cnt_q, chase_cnt_d;
    logic [31:0]   duty_q, duty_d;

    logic raw_strobe;
    logic animated;
    logic tick;

    always_comb begin
        raw_strobe  = (presc_q == PRESC_LAST);
        animated    = (mode_q == MODE_BREATH) || (mode_q == MODE_CHASE);
        tick        = raw_strobe && !paused_q && animated;

        mode_d      = mode_q;
        paused_d    = paused_q;
        presc_d     = raw_strobe ? '0 : presc_q + 1'b1;
        level_d     = level_q;
        dir_down_d  = dir_down_q;
        idx_d       = idx_q;
        chase_cnt_d = chase_cnt_q;

        // A mode change restarts every animation and overrides a coincident pause key.
        if (bus.key_mode) begin
            mode_d      = mode_e'(mode_q + 2'd1);
            paused_d    = 1'b0;
            presc_d     = '0;
            level_d     = 8'd0;
            dir_down_d  = 1'b0;
            idx_d       = 2'd0;
            chase_cnt_d = '0;
        end else begin
            if (bus.key_pause && animated) begin
                paused_d = !paused_q;
            end
            if (tick && (mode_q == MODE_BREATH)) begin
                // Direction flips on the value reached, so the level never wraps past 0/255.
                if (!dir_down_q) begin
                    level_d = level_q + 8'd1;
                    if (level_q == 8'd254) dir_down_d = 1'b1;
                end else begin
                    level_d = level_q - 8'd1;
                    if (level_q == 8'd1) dir_down_d = 1'b0;
                end
            end
            if (tick && (mode_q == MODE_CHASE)) begin
                if (chase_cnt_q == CHASE_LAST) begin
                    chase_cnt_d = '0;
                    idx_d       = idx_q + 2'd1;
                end else begin
                    chase_cnt_d = chase_cnt_q + 1'b1;
                end
            end
        end

        duty_d = 32'd0;
        case (mode_q)
            MODE_OFF:    duty_d = 32'd0;
            MODE_STEADY: duty_d = {4{bus.bright_level}};
            MODE_BREATH: duty_d = {~level_q, level_q, ~level_q, level_q};
            MODE_CHASE:  duty_d = 32'h0000_00FF << {idx_q, 3'b000};
            default:     duty_d = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q      <= MODE_OFF;
            paused_q    <= 1'b0;
            presc_q     <= '0;
            level_q     <= 8'd0;
            dir_down_q  <= 1'b0;
            idx_q       <= 2'd0;
            chase_cnt_q <= '0;
            duty_q      <= 32'd0;
        end else begin
            mode_q      <= mode_d;
            paused_q    <= paused_d;
            presc_q     <= presc_d;
            level_q     <= level_d;
            dir_down_q  <= dir_down_d;
            idx_q       <= idx_d;
            chase_cnt_q <= chase_cnt_d;
            duty_q      <= duty_d;
        end
    end

    assign bus.duty_bus = duty_q;
    assign bus.mode_out = mode_q;
    assign bus.paused   = paused_q;
    assign bus.tick     = tick;
endmodule

// File: tb/tb_led_mode_ctrl.sv
// tb/tb_led_mode_ctrl.sv - scoreboard bench for led_mode_ctrl with STEP_N=4, CHASE_DIV=2
module tb_led_mode_ctrl;
    localparam int STEP_N    = 4;
    localparam int CHASE_DIV = 2;

    logic clk;
    logic rst_n;

    led_mode_ctrl_if bus_if ();

    led_mode_ctrl #(
        .STEP_N    (STEP_N),
        .CHASE_DIV (CHASE_DIV)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_item_t;

    sb_item_t sb_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [31:0] exp);
        sb_item_t it;
        it.tag = tag;
        it.exp = exp;
        sb_q.push_back(it);
    endtask

    task automatic sb_check(input logic [31:0] obs);
        sb_item_t it;
        if (sb_q.size() == 0) begin
            check_eq("sb_underflow", 32'd0, 32'd1);
        end else begin
            it = sb_q.pop_front();
            check_eq(it.tag, obs, it.exp);
        end
    endtask

    function automatic logic [7:0] tri_lvl(input int n);
        int r;
        r = n % 510;
        return (r <= 255) ? 8'(r) : 8'(510 - r);
    endfunction

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_mode(input logic [1:0] exp_mode);
        sb_push("mode_after_key", {30'd0, exp_mode});
        bus_if.key_mode = 1'b1;
        @(negedge clk);
        bus_if.key_mode = 1'b0;
        sb_check({30'd0, bus_if.mode_out});
    endtask

    task automatic pulse_pause(input logic exp_paused);
        sb_push("paused_after_key", {31'd0, exp_paused});
        bus_if.key_pause = 1'b1;
        @(negedge clk);
        bus_if.key_pause = 1'b0;
        sb_check({31'd0, bus_if.paused});
    endtask

    task automatic wait_tick(input string tag);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 3 * STEP_N && !got; i++) begin
            @(negedge clk);
            got = bus_if.tick;
        end
        check_eq(tag, {31'd0, got}, 32'd1);
    endtask

    logic [31:0] chase_seq [4];
    int tick_cnt, chg_cnt, lat;
    logic got_tick;

    initial begin
        chase_seq[0] = 32'h0000_FF00;
        chase_seq[1] = 32'h00FF_0000;
        chase_seq[2] = 32'hFF00_0000;
        chase_seq[3] = 32'h0000_00FF;

        rst_n               = 1'b0;
        bus_if.key_mode     = 1'b0;
        bus_if.key_pause    = 1'b0;
        bus_if.bright_level = 8'h5A;
        step(3);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state and mode cycle
        check_eq("reset_duty", bus_if.duty_bus, 32'd0);
        check_eq("reset_mode", {30'd0, bus_if.mode_out}, 32'd0);
        check_eq("reset_paused", {31'd0, bus_if.paused}, 32'd0);
        check_eq("reset_tick", {31'd0, bus_if.tick}, 32'd0);

        pulse_mode(2'd1);
        sb_push("steady_duty", 32'h5A5A_5A5A);
        @(negedge clk);
        sb_check(bus_if.duty_bus);
        bus_if.bright_level = 8'h33;
        sb_push("steady_bright_change", 32'h3333_3333);
        @(negedge clk);
        sb_check(bus_if.duty_bus);
        pulse_pause(1'b0);
        step(10);
        pulse_mode(2'd2);
        step(10);
        pulse_mode(2'd3);
        step(10);
        pulse_mode(2'd0);
        sb_push("off_duty", 32'd0);
        @(negedge clk);
        sb_check(bus_if.duty_bus);

        // BREATH turnaround, anti-phase and full period
        step(9);
        pulse_mode(2'd1);
        step(10);
        pulse_mode(2'd2);
        for (int n = 1; n <= 573; n++) begin
            wait_tick("breath_tick");
            sb_push($sformatf("breath_ch0_t%0d", n), {24'd0, tri_lvl(n)});
            sb_push($sformatf("breath_ch1_t%0d", n), {24'd0, 8'hFF - tri_lvl(n)});
            step(2);
            sb_check({24'd0, bus_if.duty_bus[7:0]});
            sb_check({24'd0, bus_if.duty_bus[15:8]});
        end

        // Pause at level 0x40
        wait_tick("pause_tick_574");
        pulse_pause(1'b1);
        tick_cnt = 0;
        chg_cnt  = 0;
        @(negedge clk);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus_if.tick) tick_cnt++;
            if (bus_if.duty_bus !== 32'hBF40_BF40) chg_cnt++;
        end
        check_eq("pause_ticks", tick_cnt, 32'd0);
        check_eq("pause_duty_changes", chg_cnt, 32'd0);
        check_eq("pause_duty_hold", bus_if.duty_bus, 32'hBF40_BF40);
        pulse_pause(1'b0);
        wait_tick("resume_tick");
        sb_push("resume_duty", 32'hBE41_BE41);
        step(2);
        sb_check(bus_if.duty_bus);

        // Simultaneous keys while paused
        pulse_pause(1'b1);
        sb_push("simul_mode", 32'd3);
        sb_push("simul_paused", 32'd0);
        sb_push("simul_duty", 32'h0000_00FF);
        bus_if.key_mode  = 1'b1;
        bus_if.key_pause = 1'b1;
        @(negedge clk);
        bus_if.key_mode  = 1'b0;
        bus_if.key_pause = 1'b0;
        sb_check({30'd0, bus_if.mode_out});
        sb_check({31'd0, bus_if.paused});
        @(negedge clk);
        sb_check(bus_if.duty_bus);

        // CHASE wrap
        for (int k = 0; k < 4; k++) begin
            wait_tick("chase_tick_a");
            wait_tick("chase_tick_b");
            sb_push($sformatf("chase_duty_%0d", k), chase_seq[k]);
            step(2);
            sb_check(bus_if.duty_bus);
        end
        wait_tick("chase_tick_a");
        wait_tick("chase_tick_b");
        sb_push("chase_pre_reset", 32'h0000_FF00);
        step(2);
        sb_check(bus_if.duty_bus);

        // Mid-run asynchronous reset
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_reset_duty", bus_if.duty_bus, 32'd0);
        check_eq("async_reset_mode", {30'd0, bus_if.mode_out}, 32'd0);
        check_eq("async_reset_tick", {31'd0, bus_if.tick}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus_if.tick) tick_cnt++;
        end
        check_eq("off_no_tick", tick_cnt, 32'd0);
        // held key counts as three pulses: OFF -> STEADY -> BREATH -> CHASE
        bus_if.key_mode = 1'b1;
        step(3);
        bus_if.key_mode = 1'b0;
        check_eq("held_key_mode", {30'd0, bus_if.mode_out}, 32'd3);
        sb_push("first_tick_latency", STEP_N);
        lat = 0;
        got_tick = 1'b0;
        for (int i = 0; i < 3 * STEP_N && !got_tick; i++) begin
            @(negedge clk);
            lat++;
            got_tick = bus_if.tick;
        end
        sb_check(got_tick ? lat + 1 : 0);

        check_eq("sb_drained", sb_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
